// File: rtl/bomberman_pkg.sv
// Shared types, widths and default keycodes for the grid-locked player controller.
package bomberman_pkg;
  localparam int COORD_W = 10;
  localparam int TILE_W  = 5;

  localparam logic [7:0] KEY_UP_DEF   = 8'h1A;
  localparam logic [7:0] KEY_DN_DEF   = 8'h16;
  localparam logic [7:0] KEY_LT_DEF   = 8'h04;
  localparam logic [7:0] KEY_RT_DEF   = 8'h07;
  localparam logic [7:0] KEY_BOMB_DEF = 8'h19;

  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_QUERY = 2'd1, S_MOVE = 2'd2, S_DEAD = 2'd3} pstate_t;

  // Tile whose centre is closest to a pixel coordinate (rounds half a tile up).
  function automatic logic [TILE_W-1:0] nearest_tile(input logic [COORD_W-1:0] px,
                                                     input int tile_log2);
    return TILE_W'((px + COORD_W'(1 << (tile_log2 - 1))) >> tile_log2);
  endfunction
endpackage

// File: rtl/player_grid_ctrl_if.sv
// Collision query channel between a player controller (master) and the map block (slave).
// query_valid rises with query_col/row and all three stay stable until the cycle in which
// query_ack is high; query_blocked is meaningful only in that cycle. An ack seen while
// query_valid is low is ignored, so the map may ack in the same or any later cycle.
interface player_grid_ctrl_if;
  logic                             query_valid;
  logic [bomberman_pkg::TILE_W-1:0] query_col;
  logic [bomberman_pkg::TILE_W-1:0] query_row;
  logic                             query_ack;
  logic                             query_blocked;

  modport master (output query_valid, query_col, query_row, input query_ack, query_blocked);
  modport slave  (input query_valid, query_col, query_row, output query_ack, query_blocked);
endinterface

// File: rtl/frame_timer.sv
// Per-frame down counter: load wins, otherwise decrement and saturate at zero.
module frame_timer #(
  parameter int W    = 6,
  parameter int LOAD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic zero
);
  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             count <= '0;
    else if (load)          count <= W'(LOAD);
    else if (count != '0)   count <= count - 1'b1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/player_grid_ctrl.sv
// Tile-locked player: map collision query, stepwise motion, bomb drop with cooldown,
// and hearts with invulnerability frames.
module player_grid_ctrl
  import bomberman_pkg::*;
#(
  parameter int         TILE_LOG2     = 4,
  parameter int         GRID_W        = 20,
  parameter int         GRID_H        = 15,
  parameter int         STEP          = 2,
  parameter int         START_COL     = 1,
  parameter int         START_ROW     = 1,
  parameter int         MAX_HEARTS    = 3,
  parameter int         INVULN_FRAMES = 60,
  parameter int         BOMB_COOLDOWN = 30,
  parameter logic [7:0] KEY_UP        = KEY_UP_DEF,
  parameter logic [7:0] KEY_DN        = KEY_DN_DEF,
  parameter logic [7:0] KEY_LT        = KEY_LT_DEF,
  parameter logic [7:0] KEY_RT        = KEY_RT_DEF,
  parameter logic [7:0] KEY_BOMB      = KEY_BOMB_DEF
) (
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  input  logic [7:0]           keycode,
  input  logic                 hit,
  player_grid_ctrl_if.master   qry,
  output logic                 bomb_drop,
  output logic [TILE_W-1:0]    bomb_col,
  output logic [TILE_W-1:0]    bomb_row,
  output logic                 damage,
  output logic [2:0]           heart,
  output logic                 dead,
  output logic                 moving,
  output dir_t                 facing,
  output logic [COORD_W-1:0]   userX,
  output logic [COORD_W-1:0]   userY,
  output logic [COORD_W-1:0]   userS,
  output pstate_t              dbg_state
);
  localparam int TILE_PX = 1 << TILE_LOG2;
  localparam int INV_W   = $clog2(INVULN_FRAMES + 1);
  localparam int COOL_W  = $clog2(BOMB_COOLDOWN + 1);
  localparam logic [COORD_W-1:0] START_X = COORD_W'(START_COL << TILE_LOG2);
  localparam logic [COORD_W-1:0] START_Y = COORD_W'(START_ROW << TILE_LOG2);

  pstate_t            state, state_nx;
  logic [COORD_W-1:0] pos_x, pos_y, nx_x, nx_y, tgt_x, tgt_y;
  logic [TILE_W-1:0]  cur_col, cur_row, tgt_col, tgt_row, tgt_col_nx, tgt_row_nx;
  dir_t               move_dir, key_dir;
  logic               key_is_dir, target_ok, arrived;
  logic               bomb_key, bomb_prev, bomb_fire;
  logic               take_hit, fatal_hit, invuln_zero, cool_zero;

  // Position is tile aligned whenever a new move is sampled, so a plain shift gives the tile.
  assign cur_col = TILE_W'(pos_x >> TILE_LOG2);
  assign cur_row = TILE_W'(pos_y >> TILE_LOG2);
  assign tgt_x   = COORD_W'(tgt_col) << TILE_LOG2;
  assign tgt_y   = COORD_W'(tgt_row) << TILE_LOG2;

  always_comb begin
    key_is_dir = 1'b1;
    key_dir    = facing;
    if      (keycode == KEY_UP) key_dir = UP;
    else if (keycode == KEY_DN) key_dir = DOWN;
    else if (keycode == KEY_LT) key_dir = LEFT;
    else if (keycode == KEY_RT) key_dir = RIGHT;
    else                        key_is_dir = 1'b0;
  end

  // Edge checks run on tile indices before any +/-1, so nothing wraps.
  always_comb begin
    tgt_col_nx = cur_col;
    tgt_row_nx = cur_row;
    target_ok  = 1'b0;
    case (key_dir)
      UP:    begin target_ok = (cur_row != '0);             tgt_row_nx = cur_row - 1'b1; end
      DOWN:  begin target_ok = (int'(cur_row) < GRID_H - 1); tgt_row_nx = cur_row + 1'b1; end
      LEFT:  begin target_ok = (cur_col != '0);             tgt_col_nx = cur_col - 1'b1; end
      default: begin target_ok = (int'(cur_col) < GRID_W - 1); tgt_col_nx = cur_col + 1'b1; end
    endcase
  end

  always_comb begin
    nx_x = pos_x;
    nx_y = pos_y;
    case (move_dir)
      UP:      nx_y = pos_y - COORD_W'(STEP);
      DOWN:    nx_y = pos_y + COORD_W'(STEP);
      LEFT:    nx_x = pos_x - COORD_W'(STEP);
      default: nx_x = pos_x + COORD_W'(STEP);
    endcase
  end
  assign arrived = (nx_x == tgt_x) && (nx_y == tgt_y);

  assign take_hit  = hit && invuln_zero && (state != S_DEAD);
  assign fatal_hit = take_hit && (heart == 3'd1);
  assign bomb_key  = (keycode == KEY_BOMB);
  assign bomb_fire = bomb_key && !bomb_prev && cool_zero && (state != S_DEAD) && !fatal_hit;

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (key_is_dir && target_ok) state_nx = S_QUERY;
      S_QUERY: if (qry.query_ack) state_nx = qry.query_blocked ? S_IDLE : S_MOVE;
      S_MOVE:  if (arrived) state_nx = S_IDLE;
      S_DEAD:  state_nx = S_DEAD;
      default: state_nx = S_IDLE;
    endcase
    if (fatal_hit) state_nx = S_DEAD;
  end

  always_comb begin
    qry.query_valid = (state == S_QUERY);
    moving          = (state == S_MOVE);
    dead            = (state == S_DEAD);
  end

  assign qry.query_col = tgt_col;
  assign qry.query_row = tgt_row;

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_x     <= START_X;
      pos_y     <= START_Y;
      tgt_col   <= TILE_W'(START_COL);
      tgt_row   <= TILE_W'(START_ROW);
      move_dir  <= DOWN;
      facing    <= DOWN;
      heart     <= 3'(MAX_HEARTS);
      bomb_prev <= 1'b0;
      bomb_drop <= 1'b0;
      bomb_col  <= '0;
      bomb_row  <= '0;
      damage    <= 1'b0;
    end else begin
      bomb_prev <= bomb_key;
      bomb_drop <= bomb_fire;
      damage    <= take_hit;
      if (take_hit) heart <= heart - 3'd1;
      if (bomb_fire) begin
        bomb_col <= nearest_tile(pos_x, TILE_LOG2);
        bomb_row <= nearest_tile(pos_y, TILE_LOG2);
      end
      if (state == S_IDLE && key_is_dir) begin
        facing <= key_dir;
        if (target_ok) begin
          tgt_col  <= tgt_col_nx;
          tgt_row  <= tgt_row_nx;
          move_dir <= key_dir;
        end
      end
      if (state == S_MOVE && !fatal_hit) begin
        pos_x <= nx_x;
        pos_y <= nx_y;
      end
    end
  end

  frame_timer #(.W(INV_W), .LOAD(INVULN_FRAMES)) u_invuln (
    .clk(frame_clk), .rst_n(Reset_n), .load(take_hit), .zero(invuln_zero)
  );

  frame_timer #(.W(COOL_W), .LOAD(BOMB_COOLDOWN)) u_cooldown (
    .clk(frame_clk), .rst_n(Reset_n), .load(bomb_fire), .zero(cool_zero)
  );

  assign userX     = pos_x;
  assign userY     = pos_y;
  assign userS     = COORD_W'(TILE_PX);
  assign dbg_state = state;
endmodule

// File: tb/tb_player_grid_ctrl.sv
// Bench for player_grid_ctrl: directed scenarios plus randomized walks and bomb presses
// checked against a tile/frame-level reference model.
module tb_player_grid_ctrl;
  import bomberman_pkg::*;

  localparam int TILE_LOG2 = 4;
  localparam int TILE_PX   = 16;
  localparam int GRID_W    = 20;
  localparam int GRID_H    = 15;
  localparam int STEP      = 2;
  localparam int STEPS     = TILE_PX / STEP;
  localparam int START_COL = 1;
  localparam int START_ROW = 1;
  localparam int MAX_HEARTS = 3;
  localparam int INVULN_FRAMES = 60;
  localparam int BOMB_COOLDOWN = 30;
  localparam logic [7:0] K_UP = 8'h1A, K_DN = 8'h16, K_LT = 8'h04, K_RT = 8'h07, K_BOMB = 8'h19;

  // clock / reset
  logic clk, rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] keycode;
  logic hit, bomb_drop, damage, dead, moving;
  logic [4:0] bomb_col, bomb_row;
  logic [2:0] heart;
  dir_t facing;
  logic [9:0] userX, userY, userS;
  pstate_t dbg_state;

  player_grid_ctrl_if q();

  player_grid_ctrl #(
    .TILE_LOG2(TILE_LOG2), .GRID_W(GRID_W), .GRID_H(GRID_H), .STEP(STEP),
    .START_COL(START_COL), .START_ROW(START_ROW), .MAX_HEARTS(MAX_HEARTS),
    .INVULN_FRAMES(INVULN_FRAMES), .BOMB_COOLDOWN(BOMB_COOLDOWN),
    .KEY_UP(K_UP), .KEY_DN(K_DN), .KEY_LT(K_LT), .KEY_RT(K_RT), .KEY_BOMB(K_BOMB)
  ) dut (
    .frame_clk(clk), .Reset_n(rst_n), .keycode(keycode), .hit(hit), .qry(q),
    .bomb_drop(bomb_drop), .bomb_col(bomb_col), .bomb_row(bomb_row), .damage(damage),
    .heart(heart), .dead(dead), .moving(moving), .facing(facing),
    .userX(userX), .userY(userY), .userS(userS), .dbg_state(dbg_state)
  );

  // scoreboard / model state
  int n_cmp = 0;
  int n_bad = 0;
  int frame_no = 0;
  int m_col, m_row, m_heart, last_drop, last_hit, drop_cnt;
  logic [7:0] last_edge_key = 8'h00;
  logic [7:0] exp_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    last_edge_key = keycode;
    #1;
    frame_no++;
  endtask

  function automatic logic [7:0] key_of(input dir_t d);
    case (d)
      UP:      return K_UP;
      DOWN:    return K_DN;
      LEFT:    return K_LT;
      default: return K_RT;
    endcase
  endfunction

  function automatic bit bomb_expect(input logic [7:0] k);
    return (k == K_BOMB) && (last_edge_key != K_BOMB) &&
           (frame_no + 1 - last_drop > BOMB_COOLDOWN) && (m_heart > 0);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; keycode = 8'h00; hit = 1'b0;
    q.query_ack = 1'b0; q.query_blocked = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    m_col = START_COL; m_row = START_ROW; m_heart = MAX_HEARTS;
    last_drop = -1000; last_hit = -1000;
  endtask

  // driver: one move request answered after 'delay' extra query cycles
  task automatic move_req(input dir_t d, input bit blk, input int delay);
    int dc, dr, tc, tr, frames, sx, sy;
    bit ok;
    dc = (d == LEFT) ? -1 : (d == RIGHT) ? 1 : 0;
    dr = (d == UP) ? -1 : (d == DOWN) ? 1 : 0;
    tc = m_col + dc;
    tr = m_row + dr;
    ok = (tc >= 0) && (tc < GRID_W) && (tr >= 0) && (tr < GRID_H);
    keycode = key_of(d);
    tick();
    keycode = 8'h00;
    chk("facing", 32'(facing), 32'(d));
    chk("query_valid", 32'(q.query_valid), 32'(ok));
    if (ok) begin
      chk("query_col", 32'(q.query_col), tc);
      chk("query_row", 32'(q.query_row), tr);
      for (int i = 0; i < delay; i++) begin
        keycode = key_of(dir_t'($urandom_range(0, 3)));
        tick();
        chk("query_hold", {q.query_valid, q.query_col, q.query_row}, {1'b1, 5'(tc), 5'(tr)});
        chk("facing_hold", 32'(facing), 32'(d));
      end
      keycode = 8'h00; q.query_ack = 1'b1; q.query_blocked = blk;
      tick();
      q.query_ack = 1'b0; q.query_blocked = 1'b0;
      chk("ack_qv_drop", 32'(q.query_valid), 0);
      chk("ack_moving", 32'(moving), 32'(!blk));
      if (!blk) begin
        sx = m_col * TILE_PX;
        sy = m_row * TILE_PX;
        frames = 0;
        while (moving === 1'b1 && frames < 4 * STEPS) begin
          tick();
          frames++;
          if (frames == STEPS / 2)
            chk("mid_pos", {userX, userY}, {10'(sx + dc * TILE_PX / 2), 10'(sy + dr * TILE_PX / 2)});
        end
        chk("move_frames", frames, STEPS);
        m_col = tc;
        m_row = tr;
      end
    end
    chk("pos_x", 32'(userX), m_col * TILE_PX);
    chk("pos_y", 32'(userY), m_row * TILE_PX);
  endtask

  task automatic bomb_tick(input logic [7:0] k, input int ec, input int er);
    bit eb;
    keycode = k;
    eb = bomb_expect(k);
    tick();
    chk("bomb_drop", 32'(bomb_drop), 32'(eb));
    if (bomb_drop === 1'b1) drop_cnt++;
    if (eb) begin
      last_drop = frame_no;
      chk("bomb_col", 32'(bomb_col), ec);
      chk("bomb_row", 32'(bomb_row), er);
    end
  endtask

  initial begin
    int frames, hit_drops;
    logic [7:0] k;
    bit ed, eb;
    rst_n = 1'b0;
    drop_cnt = 0;
    do_reset();

    // reset state
    chk("rst_x", 32'(userX), 16);
    chk("rst_y", 32'(userY), 16);
    chk("rst_size", 32'(userS), 16);
    chk("rst_heart", 32'(heart), 3);
    chk("rst_facing", 32'(facing), 32'(DOWN));
    chk("rst_pulses", {bomb_drop, damage, dead, moving, q.query_valid}, 0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // right move, ack one cycle late
    move_req(RIGHT, 1'b0, 1);
    // two left moves to column 0, blocked down, then left off the grid
    move_req(LEFT, 1'b0, 0);
    move_req(LEFT, 1'b0, 2);
    move_req(DOWN, 1'b1, 2);
    move_req(LEFT, 1'b0, 0);
    chk("offgrid_state", 32'(dbg_state), 32'(S_IDLE));

    // bomb while moving right from column 0: rounds to the next tile at half way
    keycode = K_RT;
    tick();
    keycode = 8'h00; q.query_ack = 1'b1;
    tick();
    q.query_ack = 1'b0;
    repeat (4) bomb_tick(8'h00, 0, 0);
    bomb_tick(K_BOMB, 1, 1);
    keycode = 8'h00;
    frames = 0;
    while (moving === 1'b1 && frames < 20) begin
      tick();
      frames++;
    end
    chk("bomb_move_frames", frames, 3);
    m_col = 1;
    chk("bomb_move_x", 32'(userX), 16);

    // randomized walk with random blocking and ack latency
    for (int n = 0; n < 30; n++)
      move_req(dir_t'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));

    // held bomb key, early re-press, re-press once cooldown has expired
    repeat (40) tick();
    drop_cnt = 0;
    repeat (100) bomb_tick(K_BOMB, m_col, m_row);
    chk("bomb_held_drops", drop_cnt, 1);
    bomb_tick(8'h00, m_col, m_row);
    bomb_tick(K_BOMB, m_col, m_row);
    repeat (9) bomb_tick(8'h00, m_col, m_row);
    bomb_tick(K_BOMB, m_col, m_row);
    chk("bomb_early_drops", drop_cnt, 2);
    repeat (20) bomb_tick(8'h00, m_col, m_row);
    bomb_tick(K_BOMB, m_col, m_row);
    chk("bomb_late_drops", drop_cnt, 3);

    // randomized bomb key activity against the frame model
    for (int n = 0; n < 200; n++) begin
      k = ($urandom_range(0, 2) == 0) ? K_BOMB : ($urandom_range(0, 1) ? 8'h00 : 8'h55);
      bomb_tick(k, m_col, m_row);
    end
    keycode = 8'h00;
    repeat (40) tick();

    // continuous hit: damage at 0/61/122, bomb with hit at 61, fatal hit suppresses bomb at 122
    exp_q = {8'd0, 8'd61, 8'd122};
    hit_drops = 0;
    for (int i = 0; i < 200; i++) begin
      k = (i == 61 || i == 122) ? K_BOMB : 8'h00;
      keycode = k;
      hit = 1'b1;
      ed = (m_heart > 0) && (frame_no + 1 - last_hit > INVULN_FRAMES);
      eb = bomb_expect(k) && !(ed && m_heart == 1);
      tick();
      chk("damage", 32'(damage), 32'(ed));
      chk("bomb_drop_hit", 32'(bomb_drop), 32'(eb));
      if (damage === 1'b1) begin
        if (exp_q.size() == 0) chk("damage_extra", i, 255);
        else chk("damage_frame", i, 32'(exp_q.pop_front()));
      end
      if (ed) begin
        m_heart--;
        last_hit = frame_no;
      end
      if (eb) begin
        last_drop = frame_no;
        hit_drops++;
      end
      chk("heart", 32'(heart), m_heart);
    end
    hit = 1'b0;
    keycode = 8'h00;
    chk("damage_missing", exp_q.size(), 0);
    chk("hit_bomb_drops", hit_drops, 1);
    chk("dead", 32'(dead), 1);
    chk("dead_state", 32'(dbg_state), 32'(S_DEAD));

    // dead: keys do nothing
    frames = int'(userX);
    keycode = K_RT;
    tick();
    chk("dead_no_query", {q.query_valid, moving}, 0);
    keycode = 8'h00;
    tick();
    bomb_tick(K_BOMB, m_col, m_row);
    keycode = 8'h00;
    tick();
    chk("dead_frozen_x", 32'(userX), frames);

    // asynchronous reset in the middle of a move
    do_reset();
    keycode = K_RT;
    tick();
    keycode = 8'h00; q.query_ack = 1'b1;
    tick();
    q.query_ack = 1'b0;
    repeat (4) tick();
    chk("mid_move_x", 32'(userX), 24);
    #2 rst_n = 1'b0;
    #1;
    chk("async_x", 32'(userX), 16);
    chk("async_y", 32'(userY), 16);
    chk("async_flags", {q.query_valid, moving, dead}, 0);
    chk("async_heart", 32'(heart), 3);
    tick();
    rst_n = 1'b1;
    // reset during an open query, then a late ack
    keycode = K_RT;
    tick();
    keycode = 8'h00;
    chk("q_before_rst", 32'(q.query_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("q_async_drop", 32'(q.query_valid), 0);
    tick();
    rst_n = 1'b1;
    q.query_ack = 1'b1;
    repeat (2) tick();
    q.query_ack = 1'b0;
    chk("late_ack_idle", {q.query_valid, moving}, 0);
    chk("late_ack_x", 32'(userX), 16);
    chk("late_ack_heart", 32'(heart), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
